// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding
// and the helper that sizes the bit-step counter.
package serial_subtractor_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Counter must hold 0..width, so it needs clog2(width+1) bits.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_behavioral.sv
// One-bit full subtractor cell: computes x - y - c_in, producing the
// difference bit and the borrow out to the next more significant bit.
module full_subtractor_behavioral (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic diff,
  output logic c_out
);

  assign diff  = x ^ y ^ c_in;
  assign c_out = (~x & y) | (~(x ^ y) & c_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b computed LSB first through a single
// full-subtractor cell, with the borrow carried in a flop between cycles.
// A start/busy/done handshake frames each WIDTH-cycle operation.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow_out
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             diff;
  logic             c_out;
  logic             accept;

  // The only arithmetic in the datapath: one bit of a - b per cycle.
  full_subtractor_behavioral u_cell (
    .x     (a_sr[0]),
    .y     (b_sr[0]),
    .c_in  (borrow),
    .diff  (diff),
    .c_out (c_out)
  );

  // A new request is taken only when no operation is in flight.
  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  // FSM, operand/result shift registers, borrow flop and registered handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      borrow     <= 1'b0;
      count      <= '0;
      result     <= '0;
      borrow_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          result <= {diff, result[WIDTH-1:1]};
          borrow <= c_out;
          count  <= count + 1'b1;
          if (count == LAST_STEP) begin
            // Final bit: the cell's borrow is the answer to a < b.
            borrow_out <= c_out;
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE behave alike: accept a request or settle in IDLE.
          if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            count  <= '0;
            result <= '0;
            state  <= ST_SHIFT;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
